uart_tx_fifo: RTL and testbench

//   Byte buffer that sits directly upstream of uart_tx. Accepts bytes from a host

---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/uart_tx_fifo.sv | 106 ++++++++++
 tb/tb_uart_tx_fifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default character width and TX FIFO FSM encoding.
package uart_pkg;

    localparam int DBIT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO: circular RAM, pointers, count and registered flags.
module sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_d;
    logic          push;
    logic          pop;

    // Write is gated by the registered full flag, so a pop in the same
    // cycle never makes room for a write that arrives while full.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (push && !pop) begin
            count_d = count + 1'b1;
        end else if (pop && !push) begin
            count_d = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_d;
            full  <= (count_d == DEPTH);
            empty <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx; paces launches on tx_done_tick.
// Optional status ports (level, sticky overflow) with UART_TX_FIFO_STATUS_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DBIT       = DBIT_DEF,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    output logic              full,
    output logic              empty,
    output logic              busy,
    output logic              tx_start,
    output logic [DBIT-1:0]   tx_data,
`ifdef UART_TX_FIFO_STATUS_EN
    output logic [DEPTH_LOG2:0] level,
    output logic              overflow,
`endif
    input  logic              tx_done_tick
);

    tx_state_t           state_q;
    tx_state_t           state_d;
    logic                pop;
    logic [DBIT-1:0]     head;
    logic [DEPTH_LOG2:0] count;

    sync_fifo #(
        .W  (DBIT),
        .AW (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        busy    = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (!empty) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                pop     = 1'b1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done_tick) begin
                    state_d = (count != '0) ? LAUNCH : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // tx_data is loaded on entry to LAUNCH so it is valid while tx_start
    // is high; the head itself is popped during the LAUNCH cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= (state_d == LAUNCH);
            if (state_d == LAUNCH) begin
                tx_data <= head;
            end
        end
    end

`ifdef UART_TX_FIFO_STATUS_EN
    assign level = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a uart_tx done-tick model.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       empty;
    logic       busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done_tick = 1'b0;
`ifdef UART_TX_FIFO_STATUS_EN
    logic [4:0] level;
    logic       overflow;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];
    int   mcount     = 0;
    int   cd         = 0;
    int   cyc        = 0;
    int   exp_launch = -1;
    bit   exp_idle   = 0;
    bit   waiting    = 0;
    bit   hold       = 0;
    bit   stray_req  = 0;
    bit   ovf_m      = 0;
    logic [7:0] last_data = 8'h00;

    uart_tx_fifo #(
        .DBIT       (8),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .busy         (busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
`ifdef UART_TX_FIFO_STATUS_EN
        .level        (level),
        .overflow     (overflow),
`endif
        .tx_done_tick (tx_done_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model and uart_tx stand-in, evaluated mid-cycle.
    always @(negedge clk) begin
        int  old_cnt;
        bit  acc;
        cyc++;
        tx_done_tick = 1'b0;
        if (stray_req) begin
            tx_done_tick = 1'b1;
            stray_req = 0;
        end else if (cd == 1 && !hold) begin
            tx_done_tick = 1'b1;
            cd = 0;
        end else if (cd > 1) begin
            cd--;
        end
        if (rst) begin
            q.delete();
            mcount = 0;
            cd = 0;
            exp_launch = -1;
            exp_idle = 0;
            waiting = 0;
            ovf_m = 0;
            last_data = 8'h00;
        end else begin
            chk("full", full, mcount == 16);
            chk("empty", empty, mcount == 0);
`ifdef UART_TX_FIFO_STATUS_EN
            chk("level", level, mcount);
            chk("overflow", overflow, ovf_m);
`endif
            if (exp_idle) begin
                chk("busy_after_done", busy, 0);
                exp_idle = 0;
            end
            old_cnt = mcount;
            if (tx_start) begin
                if (q.size() == 0) begin
                    chk("stray_start", 1, 0);
                end else begin
                    last_data = q.pop_front();
                    chk("tx_data", tx_data, last_data);
                end
                chk("busy_launch", busy, 1);
                if (exp_launch >= 0) chk("launch_cyc", cyc, exp_launch);
                exp_launch = -1;
                cd = 20;
                waiting = 1;
            end else begin
                chk("tx_data_hold", tx_data, last_data);
                if (exp_launch >= 0 && cyc >= exp_launch) begin
                    chk("launch_miss", cyc, exp_launch);
                    exp_launch = -1;
                end
            end
            acc = wr_en && (old_cnt < 16);
            if (wr_en && !acc) ovf_m = 1;
            if (acc && !busy && old_cnt == 0 && exp_launch < 0)
                exp_launch = cyc + 2;
            if (acc) q.push_back(wr_data);
            mcount = old_cnt + int'(acc) - int'(tx_start);
            if (tx_done_tick && waiting && !tx_start) begin
                waiting = 0;
                if (old_cnt > 0) exp_launch = cyc + 1;
                else exp_idle = 1;
            end
        end
    end

    task automatic wr(input logic [7:0] d);
        @(posedge clk);
        #1;
        wr_en = 1'b1;
        wr_data = d;
    endtask

    task automatic idle_wr();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !waiting && mcount == 0) done = 1;
        end
        if (!done) chk("drain_timeout", 1, 0);
        repeat (3) @(negedge clk);
        chk("drain_empty", empty, 1);
        chk("drain_busy", busy, 0);
    endtask

    initial begin
        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_data", tx_data, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // single byte
        wr(8'hA5);
        idle_wr();
        wait_drain();
        chk("single_data", tx_data, 8'hA5);

        // burst
        for (int i = 1; i <= 16; i++) wr(8'(i));
        idle_wr();
        wait_drain();

        // overflow
        hold = 1;
        for (int i = 0; i < 17; i++) wr(8'(8'h20 + i));
        wr(8'hFF);
        idle_wr();
        @(negedge clk);
        chk("ovf_full", full, 1);
        chk("ovf_cnt", mcount, 16);
`ifdef UART_TX_FIFO_STATUS_EN
        chk("ovf_flag", overflow, 1);
        chk("ovf_level", level, 16);
`endif
        repeat (30) @(negedge clk);
        hold = 0;
        wait_drain();

        // simultaneous write and pop in LAUNCH
        wr(8'h5A);
        idle_wr();
        wr(8'hC3);
        idle_wr();
        @(negedge clk);
        chk("simul_empty", empty, 0);
`ifdef UART_TX_FIFO_STATUS_EN
        chk("simul_level", level, 1);
`endif
        wait_drain();
        chk("simul_last", tx_data, 8'hC3);

        // mid-frame reset
        for (int i = 0; i < 6; i++) wr(8'(8'h40 + i));
        idle_wr();
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_empty", empty, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        stray_req = 1;
        repeat (40) @(negedge clk);
        chk("post_rst_empty", empty, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_queue", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
